// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, MEM-stage branch
// redirect, data-memory wait/timeout and perf counters.
module pipeline_hazard_ctrl #(
  parameter int REG_W       = 6,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_memread,
  input  logic [1:0]       mem_brlogic,
  input  logic             mem_z,
  input  logic             mem_n,
  input  logic             mem_memread,
  input  logic             mem_memwrite,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             exmem_hold,
  output logic             memwb_bubble,
  output logic             pc_src,
  output logic [1:0]       state,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    ERR      = 2'b10
  } state_e;

  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WC_W-1:0] WC_TO  = WC_W'(MEM_TIMEOUT);
  localparam logic [WC_W-1:0] WC_ONE = WC_W'(1);
  localparam logic [CNT_W-1:0] CMAX  = '1;

  state_e           state_q, state_d;
  logic [WC_W-1:0]  wcnt_q, wcnt_d;
  logic [WC_W-1:0]  wcnt_inc;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic taken;
  logic mem_stall;
  logic lu;
  logic rs_hit;
  logic rt_hit;
  logic ev_run;
  logic do_stall;
  logic do_flush;

  always_comb begin
    taken = ((mem_brlogic == 2'b01) & mem_z)
          | ((mem_brlogic == 2'b10) & mem_n)
          |  (mem_brlogic == 2'b11);
    mem_stall = (mem_memread | mem_memwrite) & ~dmem_ready;
    rs_hit = id_uses_rs & (id_rs == ex_rd);
    rt_hit = id_uses_rt & (id_rt == ex_rd);
    lu = ex_memread & (ex_rd != '0) & (rs_hit | rt_hit);
    wcnt_inc = wcnt_q + WC_ONE;
  end

  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    idex_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    exmem_flush  = 1'b0;
    exmem_hold   = 1'b0;
    memwb_bubble = 1'b0;
    pc_src       = 1'b0;
    state_d      = state_q;
    wcnt_d       = wcnt_q;
    mem_err_d    = mem_err_q;
    ev_run       = 1'b0;
    do_stall     = 1'b0;
    do_flush     = 1'b0;

    unique case (state_q)
      RUN: begin
        if (mem_stall) begin
          state_d  = MEM_WAIT;
          wcnt_d   = WC_ONE;
          do_stall = 1'b1;
        end else begin
          ev_run = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!dmem_ready) begin
          wcnt_d   = wcnt_inc;
          do_stall = 1'b1;
          if (wcnt_inc >= WC_TO) begin
            state_d   = ERR;
            mem_err_d = 1'b1;
          end
        end else begin
          state_d = RUN;
          wcnt_d  = '0;
          ev_run  = 1'b1;
        end
      end
      ERR: begin
        mem_err_d = 1'b1;
      end
      default: begin
        state_d = RUN;
        wcnt_d  = '0;
      end
    endcase

    // A stalled access and ERR both freeze the back end the same way
    if (do_stall || state_q == ERR) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_write   = 1'b0;
      exmem_hold   = 1'b1;
      memwb_bubble = 1'b1;
    end

    if (ev_run) begin
      if (taken) begin
        pc_src      = 1'b1;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
        do_flush    = 1'b1;
      end else if (lu) begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        idex_flush = 1'b1;
        do_stall   = 1'b1;
      end
    end

    if (RESET) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_write   = 1'b0;
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
      exmem_flush  = 1'b1;
      exmem_hold   = 1'b0;
      memwb_bubble = 1'b1;
      pc_src       = 1'b0;
    end

    stall_d = stall_q;
    if (do_stall && stall_q != CMAX) begin
      stall_d = stall_q + 1'b1;
    end
    flush_d = flush_q;
    if (do_flush && flush_q != CMAX) begin
      flush_d = flush_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= RUN;
      wcnt_q    <= '0;
      mem_err_q <= 1'b0;
      stall_q   <= '0;
      flush_q   <= '0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      mem_err_q <= mem_err_d;
      stall_q   <= stall_d;
      flush_q   <= flush_d;
    end
  end

  assign state       = state_q;
  assign mem_err     = mem_err_q;
  assign stall_count = stall_q;
  assign flush_count = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with a queue scoreboard.
module tb_pipeline_hazard_ctrl;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [5:0] id_rs, id_rt, ex_rd;
  logic       id_uses_rs, id_uses_rt, ex_memread;
  logic [1:0] mem_brlogic;
  logic       mem_z, mem_n, mem_memread, mem_memwrite, dmem_ready;

  logic        pc_write, ifid_write, idex_write;
  logic        ifid_flush, idex_flush, exmem_flush;
  logic        exmem_hold, memwb_bubble, pc_src;
  logic [1:0]  state;
  logic        mem_err;
  logic [15:0] stall_count, flush_count;

  logic        s_pcw, s_ifw, s_idw, s_iff, s_idf, s_exf, s_exh, s_mwb, s_pcs;
  logic [1:0]  s_state;
  logic        s_err;
  logic [2:0]  s_stall, s_flush;

  logic [8:0] strb;
  assign strb = {pc_write, ifid_write, idex_write,
                 ifid_flush, idex_flush, exmem_flush,
                 exmem_hold, memwb_bubble, pc_src};

  localparam logic [8:0] DEF = 9'b111_000_000;
  localparam logic [8:0] RST = 9'b000_111_010;
  localparam logic [8:0] STL = 9'b000_000_110;
  localparam logic [8:0] BR  = 9'b111_111_001;
  localparam logic [8:0] LU  = 9'b001_010_000;

  typedef struct {
    string       tag;
    logic [8:0]  strb;
    logic [1:0]  st;
    logic        err;
    int          sc;
    int          fc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int sc_e = 0;
  int fc_e = 0;

  always #5 CLK = ~CLK;

  pipeline_hazard_ctrl #(.REG_W(6), .MEM_TIMEOUT(8), .CNT_W(16)) dut (
    .CLK(CLK), .RESET(RESET),
    .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_rd(ex_rd), .ex_memread(ex_memread),
    .mem_brlogic(mem_brlogic), .mem_z(mem_z), .mem_n(mem_n),
    .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
    .dmem_ready(dmem_ready),
    .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .exmem_hold(exmem_hold),
    .memwb_bubble(memwb_bubble), .pc_src(pc_src),
    .state(state), .mem_err(mem_err),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  pipeline_hazard_ctrl #(.REG_W(6), .MEM_TIMEOUT(8), .CNT_W(3)) u_sat (
    .CLK(CLK), .RESET(RESET),
    .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_rd(ex_rd), .ex_memread(ex_memread),
    .mem_brlogic(mem_brlogic), .mem_z(mem_z), .mem_n(mem_n),
    .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
    .dmem_ready(dmem_ready),
    .pc_write(s_pcw), .ifid_write(s_ifw), .idex_write(s_idw),
    .ifid_flush(s_iff), .idex_flush(s_idf),
    .exmem_flush(s_exf), .exmem_hold(s_exh),
    .memwb_bubble(s_mwb), .pc_src(s_pcs),
    .state(s_state), .mem_err(s_err),
    .stall_count(s_stall), .flush_count(s_flush)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_in();
    id_rs = '0; id_rt = '0; ex_rd = '0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; ex_memread = 1'b0;
    mem_brlogic = 2'b00; mem_z = 1'b0; mem_n = 1'b0;
    mem_memread = 1'b0; mem_memwrite = 1'b0; dmem_ready = 1'b1;
  endtask

  // Counters are registered: the expectation pushed holds the values
  // accumulated before this cycle's edge, then ds/df are applied.
  task automatic step(string tag, logic [8:0] es, logic [1:0] est,
                      logic eerr, int ds, int df);
    exp_t e;
    exp_t g;
    e.tag = tag; e.strb = es; e.st = est; e.err = eerr;
    e.sc = sc_e; e.fc = fc_e;
    sb.push_back(e);
    @(negedge CLK);
    g = sb.pop_front();
    chk({g.tag, ".strb"},  32'(strb),        32'(g.strb));
    chk({g.tag, ".state"}, 32'(state),       32'(g.st));
    chk({g.tag, ".err"},   32'(mem_err),     32'(g.err));
    chk({g.tag, ".stall"}, 32'(stall_count), 32'(g.sc));
    chk({g.tag, ".flush"}, 32'(flush_count), 32'(g.fc));
    chk({g.tag, ".sat"},   32'(s_stall),     32'((g.sc > 7) ? 7 : g.sc));
    sc_e = (sc_e + ds > 65535) ? 65535 : sc_e + ds;
    fc_e = (fc_e + df > 65535) ? 65535 : fc_e + df;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RESET = 1'b1;
    clr_in();
    step("rst", RST, 2'b00, 1'b0, 0, 0);
    RESET = 1'b0;
    step("idle", DEF, 2'b00, 1'b0, 0, 0);

    ex_memread = 1'b1; ex_rd = 6'd5; id_rs = 6'd5; id_uses_rs = 1'b1;
    step("lu_rs", LU, 2'b00, 1'b0, 1, 0);
    ex_memread = 1'b0;
    step("lu_clr", DEF, 2'b00, 1'b0, 0, 0);
    ex_memread = 1'b1; ex_rd = 6'd0; id_rs = 6'd0;
    step("lu_r0", DEF, 2'b00, 1'b0, 0, 0);
    clr_in();
    ex_memread = 1'b1; ex_rd = 6'd7; id_rt = 6'd7; id_uses_rt = 1'b1;
    step("lu_rt", LU, 2'b00, 1'b0, 1, 0);
    id_uses_rt = 1'b0;
    step("lu_nouse", DEF, 2'b00, 1'b0, 0, 0);
    clr_in();

    mem_brlogic = 2'b01; mem_z = 1'b1;
    step("br_z", BR, 2'b00, 1'b0, 0, 1);
    mem_brlogic = 2'b10; mem_z = 1'b1; mem_n = 1'b0;
    step("br_n0", DEF, 2'b00, 1'b0, 0, 0);
    mem_n = 1'b1;
    step("br_n1", BR, 2'b00, 1'b0, 0, 1);
    mem_brlogic = 2'b01; mem_z = 1'b0;
    step("br_z0", DEF, 2'b00, 1'b0, 0, 0);
    mem_brlogic = 2'b11;
    step("br_unc", BR, 2'b00, 1'b0, 0, 1);
    ex_memread = 1'b1; ex_rd = 6'd9; id_rs = 6'd9; id_uses_rs = 1'b1;
    step("br_lu", BR, 2'b00, 1'b0, 0, 1);
    clr_in();

    mem_memwrite = 1'b1;
    step("zero_wait", DEF, 2'b00, 1'b0, 0, 0);
    clr_in();
    mem_memread = 1'b1; dmem_ready = 1'b0;
    step("mw0", STL, 2'b00, 1'b0, 1, 0);
    step("mw1", STL, 2'b01, 1'b0, 1, 0);
    step("mw2", STL, 2'b01, 1'b0, 1, 0);
    step("mw3", STL, 2'b01, 1'b0, 1, 0);
    dmem_ready = 1'b1;
    step("mw_rel", DEF, 2'b01, 1'b0, 0, 0);
    clr_in();
    step("mw_run", DEF, 2'b00, 1'b0, 0, 0);

    mem_memread = 1'b1; dmem_ready = 1'b0;
    step("rw0", STL, 2'b00, 1'b0, 1, 0);
    step("rw1", STL, 2'b01, 1'b0, 1, 0);
    step("rw2", STL, 2'b01, 1'b0, 1, 0);
    RESET = 1'b1;
    sc_e = 0; fc_e = 0;
    step("rst_mid", RST, 2'b00, 1'b0, 0, 0);
    RESET = 1'b0;
    clr_in();
    step("post_rst", DEF, 2'b00, 1'b0, 0, 0);

    mem_memread = 1'b1; dmem_ready = 1'b0;
    step("to0", STL, 2'b00, 1'b0, 1, 0);
    for (int i = 1; i < 8; i++) begin
      step($sformatf("to%0d", i), STL, 2'b01, 1'b0, 1, 0);
    end
    step("err0", STL, 2'b10, 1'b1, 0, 0);
    clr_in();
    mem_brlogic = 2'b11;
    step("err1", STL, 2'b10, 1'b1, 0, 0);
    step("err2", STL, 2'b10, 1'b1, 0, 0);
    RESET = 1'b1;
    sc_e = 0; fc_e = 0;
    step("err_rst", RST, 2'b00, 1'b0, 0, 0);
    RESET = 1'b0;
    clr_in();
    step("final", DEF, 2'b00, 1'b0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
